fifo_burst_reader: RTL

//   Read-side controller for the async FIFO's read domain; successor to the single-word read logic.

---
 rtl/fifo_burst_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Burst read controller for a FWFT FIFO, feeding a valid/ready stream through a 2-entry skid buffer.
// Optional empty-stall timeout abort is compiled in with `define FBR_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              rclk,
  input  logic              Rrst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rempty,
  output logic              rinc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_rd,
  output logic              timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] entry0, entry1;
  logic [1:0]        fill, fill_nxt;
  logic [CNT_W-1:0]  remaining;
  logic              accept;
  logic              launch;
  logic              to_hit;

  assign out_valid = (fill != 2'd0);
  assign out_data  = entry0;
  assign accept    = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign launch    = (state == ST_IDLE) && start && !abort;

  // The fill<2 term is what keeps the skid buffer from overflowing.
  assign rinc = (state == ST_BURST) && !rempty && !abort &&
                (remaining != '0) && (fill < 2'd2);

  always_comb begin
    fill_nxt = fill;
    case ({rinc, accept})
      2'b10:   fill_nxt = fill + 2'd1;
      2'b01:   fill_nxt = fill - 2'd1;
      default: fill_nxt = fill;
    endcase
  end

`ifdef FBR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt;
  logic            timeout_q;

  // Fires on the TIMEOUT-th consecutive empty cycle spent in BURST.
  assign to_hit = (state == ST_BURST) && rempty && (stall_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge rclk) begin
    if (Rrst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == ST_BURST) && rempty && !to_hit) stall_cnt <= stall_cnt + TO_W'(1);
      else                                          stall_cnt <= '0;
      if (launch)      timeout_q <= 1'b0;
      else if (to_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (Rrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = (burst_len == '0) ? ST_DONE : ST_BURST;
      ST_BURST: if (abort || to_hit || (rinc && remaining == CNT_W'(1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fill_nxt == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: buffer entries are reset too, because entry0 drives out_data directly.
  always_ff @(posedge rclk) begin
    if (Rrst) begin
      fill      <= 2'd0;
      entry0    <= '0;
      entry1    <= '0;
      remaining <= '0;
      words_rd  <= '0;
    end else begin
      fill <= fill_nxt;
      if (launch) begin
        remaining <= burst_len;
        words_rd  <= '0;
      end else if (rinc) begin
        remaining <= remaining - CNT_W'(1);
        words_rd  <= words_rd + CNT_W'(1);
      end
      // A pop never coincides with fill==2, so entry1 is only ever shifted or loaded.
      if (accept) begin
        if (fill == 2'd2) entry0 <= entry1;
        else if (rinc)    entry0 <= rdata;
      end else if (rinc) begin
        if (fill == 2'd0) entry0 <= rdata;
        else              entry1 <= rdata;
      end
    end
  end

endmodule
